// File: rtl/memory_bus_arbiter_pkg.sv
// Shared constants, request record and slot state for memory_bus_arbiter.
// Optional build macro: MEMORY_BUS_ARB_LIMIT_EN (see memory_bus_arbiter.sv).
package memory_bus_pkg;

  localparam int ADDR_W   = 29;
  localparam int DATA_W   = 24;
  localparam int BUS_ID_W = 8;
  localparam int AXI_ID_W = 6;

  typedef struct packed {
    logic                write;
    logic [BUS_ID_W-1:0] id;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data;
  } req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Custom memory bus between the arbiter (master) and the AXI bridge (slave).
interface memory_bus_arbiter_if;
  import memory_bus_pkg::*;

  // Both directions are valid/taken handshakes: a beat transfers on a clock edge
  // where valid and taken are both high; the sender holds the beat stable until then.
  logic                msValid;
  logic                msWrite;
  logic [BUS_ID_W-1:0] msID;
  logic [ADDR_W-1:0]   msAddress;
  logic [DATA_W-1:0]   msData;
  logic                msTaken;

  logic                smValid;
  logic [BUS_ID_W-1:0] smID;
  logic [DATA_W-1:0]   smData;
  logic                smTaken;

  modport master (
    output msValid, msWrite, msID, msAddress, msData,
    input  msTaken,
    input  smValid, smID, smData,
    output smTaken
  );

  modport slave (
    input  msValid, msWrite, msID, msAddress, msData,
    output msTaken,
    output smValid, smID, smData,
    input  smTaken
  );

endinterface

// File: rtl/memory_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int j;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant     = N'(1) << j;
        grant_idx = IDX_W'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin merge of NUM_MASTERS request ports into one registered bus slot,
// with index-routed read responses. Macro MEMORY_BUS_ARB_LIMIT_EN adds per-master read limits.
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int LOCAL_ID_W      = 4,
  parameter int IDX_W           = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic [NUM_MASTERS-1:0]                 m_valid,
  output logic [NUM_MASTERS-1:0]                 m_taken,
  input  logic [NUM_MASTERS-1:0]                 m_write,
  input  logic [NUM_MASTERS-1:0][LOCAL_ID_W-1:0] m_id,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]     m_address,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]     m_data,
  output logic [NUM_MASTERS-1:0]                 r_valid,
  input  logic [NUM_MASTERS-1:0]                 r_taken,
  output logic [LOCAL_ID_W-1:0]                  r_id,
  output logic [DATA_W-1:0]                      r_data,
  memory_bus_arbiter_if.master                   bus,
  output slot_state_t                            slot_state
);

  localparam int TAG_W = IDX_W + LOCAL_ID_W;
  localparam int PAD_W = BUS_ID_W - TAG_W;

  // The bridge forwards only the low AXI_ID_W bits of msID.
  if (TAG_W > AXI_ID_W || MAX_OUTSTANDING < 1) begin : g_bad_config
    $error("memory_bus_arbiter: illegal ID width or outstanding limit");
  end

  slot_state_t            state;
  req_t                   slot;
  logic [IDX_W-1:0]       ptr;
  logic                   can_load;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] arb_req;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic [IDX_W-1:0]       next_ptr;
  logic [IDX_W-1:0]       resp_idx;
  logic                   resp_hit;
  logic                   unused_id_bits;

  assign can_load = (state == SLOT_EMPTY) || bus.msTaken;
  assign arb_req  = eligible & {NUM_MASTERS{can_load && rst_n_in}};

`ifdef MEMORY_BUS_ARB_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_MASTERS-1:0][CNT_W-1:0] out_cnt;
  logic [NUM_MASTERS-1:0]            cnt_inc;
  logic [NUM_MASTERS-1:0]            cnt_dec;

  // Writes never return a response, so only reads are throttled.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = m_valid[i] && (m_write[i] || (out_cnt[i] < CNT_W'(MAX_OUTSTANDING)));
      cnt_inc[i]  = grant[i] && !m_write[i];
      cnt_dec[i]  = bus.smValid && bus.smTaken && resp_hit && (resp_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      out_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) out_cnt[i] <= out_cnt[i] + 1'b1;
        else if (cnt_dec[i] && !cnt_inc[i] && out_cnt[i] != '0) out_cnt[i] <= out_cnt[i] - 1'b1;
      end
    end
  end
`else
  assign eligible = m_valid;
`endif

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (arb_req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign m_taken  = grant;
  assign next_ptr = (int'(grant_idx) == NUM_MASTERS - 1) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= SLOT_EMPTY;
      slot  <= '0;
      ptr   <= '0;
    end else if (grant_any) begin
      state        <= SLOT_FULL;
      slot.write   <= m_write[grant_idx];
      slot.id      <= {{PAD_W{1'b0}}, grant_idx, m_id[grant_idx]};
      slot.address <= m_address[grant_idx];
      slot.data    <= m_data[grant_idx];
      ptr          <= next_ptr;
    end else if (bus.msTaken) begin
      state <= SLOT_EMPTY;
    end
  end

  assign bus.msValid   = (state == SLOT_FULL);
  assign bus.msWrite   = slot.write;
  assign bus.msID      = slot.id;
  assign bus.msAddress = slot.address;
  assign bus.msData    = slot.data;
  assign slot_state    = state;

  // Responses carrying an index with no master behind it are swallowed.
  assign resp_idx       = bus.smID[LOCAL_ID_W +: IDX_W];
  assign resp_hit       = int'(resp_idx) < NUM_MASTERS;
  assign r_id           = bus.smID[LOCAL_ID_W-1:0];
  assign r_data         = bus.smData;
  assign unused_id_bits = ^bus.smID[BUS_ID_W-1:TAG_W];

  always_comb begin
    r_valid     = '0;
    bus.smTaken = 1'b0;
    if (rst_n_in) begin
      if (resp_hit) begin
        r_valid[resp_idx] = bus.smValid;
        bus.smTaken       = r_taken[resp_idx];
      end else begin
        bus.smTaken = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: random masters/bridge traffic against a
// round-robin reference model; honours MEMORY_BUS_ARB_LIMIT_EN when defined.
module tb_memory_bus_arbiter;
  import memory_bus_pkg::*;

  localparam int N    = 4;
  localparam int LID  = 4;
  localparam int IW   = 2;
  localparam int MAXO = 8;
  localparam int REQ_W = 1 + BUS_ID_W + ADDR_W + DATA_W;

  // clock / reset
  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [N-1:0]                 m_valid;
  logic [N-1:0]                 m_taken;
  logic [N-1:0]                 m_write;
  logic [N-1:0][LID-1:0]        m_id;
  logic [N-1:0][ADDR_W-1:0]     m_address;
  logic [N-1:0][DATA_W-1:0]     m_data;
  logic [N-1:0]                 r_valid;
  logic [N-1:0]                 r_taken;
  logic [LID-1:0]               r_id;
  logic [DATA_W-1:0]            r_data;
  slot_state_t                  slot_state;

  memory_bus_arbiter_if bus ();

  memory_bus_arbiter #(
    .NUM_MASTERS     (N),
    .LOCAL_ID_W      (LID),
    .IDX_W           (IW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .m_valid    (m_valid),
    .m_taken    (m_taken),
    .m_write    (m_write),
    .m_id       (m_id),
    .m_address  (m_address),
    .m_data     (m_data),
    .r_valid    (r_valid),
    .r_taken    (r_taken),
    .r_id       (r_id),
    .r_data     (r_data),
    .bus        (bus),
    .slot_state (slot_state)
  );

  // scoreboard state
  int               tests_run = 0;
  int               failures  = 0;
  logic [REQ_W-1:0] exp_q[$];
  logic [REQ_W-1:0] mon_e;

  // reference model state
  bit full_m = 1'b0;
  int ptr_m  = 0;
  int cnt_m[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called one step after inputs settle, before the next rising edge.
  task automatic model_cycle();
    int          g;
    int          idx;
    bit          can_load;
    bit          exp_st;
    bit          inc;
    bit          dec;
    logic [N-1:0] elig;
    logic [N-1:0] exp_rv;
    if (!rst_n_in) begin
      chk("m_taken_in_reset", 64'(m_taken), 64'd0);
      chk("r_valid_in_reset", 64'(r_valid), 64'd0);
      chk("smTaken_in_reset", 64'(bus.smTaken), 64'd0);
      full_m = 1'b0;
      ptr_m  = 0;
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
      exp_q.delete();
      return;
    end
    chk("msValid", 64'(bus.msValid), 64'(full_m));

    for (int i = 0; i < N; i++) begin
      elig[i] = m_valid[i];
`ifdef MEMORY_BUS_ARB_LIMIT_EN
      if (!m_write[i] && cnt_m[i] >= MAXO) elig[i] = 1'b0;
`endif
    end
    can_load = !full_m || bus.msTaken;
    g = -1;
    if (can_load) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && elig[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
    end
    chk("m_taken", 64'(m_taken), (g < 0) ? 64'd0 : (64'd1 << g));

    idx    = int'(bus.smID[LID+IW-1:LID]);
    exp_rv = '0;
    if (idx < N && bus.smValid) exp_rv[idx] = 1'b1;
    exp_st = (idx < N) ? r_taken[idx] : 1'b1;
    chk("r_valid", 64'(r_valid), 64'(exp_rv));
    chk("smTaken", 64'(bus.smTaken), 64'(exp_st));
    if (bus.smValid) begin
      chk("r_id", 64'(r_id), 64'(bus.smID & 8'h0F));
      chk("r_data", 64'(r_data), 64'(bus.smData));
    end

    for (int i = 0; i < N; i++) begin
      inc = (g == i) && !m_write[i];
      dec = bus.smValid && exp_st && (idx == i);
      if (inc && !dec) cnt_m[i]++;
      else if (dec && !inc && cnt_m[i] > 0) cnt_m[i]--;
    end

    if (g >= 0) begin
      exp_q.push_back({m_write[g], 8'((g << LID) | int'(m_id[g])), m_address[g], m_data[g]});
      full_m = 1'b1;
      ptr_m  = (g + 1) % N;
    end else if (bus.msTaken) begin
      full_m = 1'b0;
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    m_valid       = '0;
    m_write       = '0;
    m_id          = '0;
    m_address     = '0;
    m_data        = '0;
    r_taken       = '0;
    bus.msTaken   = 1'b0;
    bus.smValid   = 1'b0;
    bus.smID      = '0;
    bus.smData    = '0;
  endtask

  task automatic drive_rand(input int vprob, input int tprob);
    for (int i = 0; i < N; i++) begin
      m_valid[i]   = ($urandom_range(99) < vprob);
      m_write[i]   = 1'($urandom_range(1));
      m_id[i]      = LID'($urandom);
      m_address[i] = ADDR_W'($urandom);
      m_data[i]    = DATA_W'($urandom);
      r_taken[i]   = 1'($urandom_range(1));
    end
    bus.msTaken = ($urandom_range(99) < tprob);
    bus.smValid = 1'($urandom_range(1));
    bus.smID    = 8'($urandom_range(255));
    bus.smData  = DATA_W'($urandom);
  endtask

  // monitor: retire one expected request per accepted bus beat
  initial begin
    forever begin
      @(negedge clk_in);
      #2;
      if (rst_n_in && bus.msValid && bus.msTaken) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          failures++;
          $display("FAIL bus_accept: got msID=%0h with no request expected", bus.msID);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_request", 64'({bus.msWrite, bus.msID, bus.msAddress, bus.msData}), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    drive_idle();
    rst_n_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      #1 model_cycle();
    end

    // reset state
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1 model_cycle();
    chk("reset_msID", 64'(bus.msID), 64'd0);
    chk("reset_msAddress", 64'(bus.msAddress), 64'd0);

    // single read from master 0
    @(negedge clk_in);
    m_valid      = 4'b0001;
    m_write      = '0;
    m_id[0]      = 4'd3;
    m_address[0] = 29'h100;
    #1 model_cycle();
    chk("t1_m_taken", 64'(m_taken), 64'b0001);
    @(negedge clk_in);
    m_valid = '0;
    #1 model_cycle();
    chk("t1_msValid", 64'(bus.msValid), 64'd1);
    chk("t1_msID", 64'(bus.msID), 64'h03);
    chk("t1_msAddress", 64'(bus.msAddress), 64'h100);
    @(negedge clk_in);
    bus.msTaken = 1'b1;
    #1 model_cycle();

    // response routed to master 2
    @(negedge clk_in);
    bus.msTaken = 1'b0;
    bus.smValid = 1'b1;
    bus.smID    = 8'h2A;
    bus.smData  = 24'hABCDEF;
    r_taken     = 4'b0100;
    #1 model_cycle();
    chk("t4_r_valid", 64'(r_valid), 64'b0100);
    chk("t4_r_id", 64'(r_id), 64'hA);
    chk("t4_r_data", 64'(r_data), 64'hABCDEF);
    chk("t4_smTaken", 64'(bus.smTaken), 64'd1);

    // random traffic with a reset landing mid-stream
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_in);
      drive_rand((c < 200) ? 40 : 90, ((c % 50) < 10) ? 0 : 70);
      rst_n_in = (c != 250) && (c != 251);
      if (!rst_n_in) bus.msTaken = 1'b0;
      #1 model_cycle();
    end

    // all masters busy, bridge always ready
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      drive_rand(100, 100);
      bus.smValid = 1'b0;
      #1 model_cycle();
    end

    // bridge stalls, then resumes
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_in);
      drive_rand(100, 0);
      bus.msTaken = (c >= 6);
      #1 model_cycle();
    end

    // drain
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      drive_idle();
      bus.msTaken = 1'b1;
      #1 model_cycle();
    end
    @(negedge clk_in);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
